scudsp_dma_engine: RTL and testbench
====================================

# scudsp_dma_engine

Executes SCU DSP DMA commands: takes the decoded DMA command fields (start, direction, destination/source RAM, increment, hold, count) and moves 32-bit words between the D0 bus and DSP data/program RAM. It sits beside the DSP instruction decoder and sequencer, asserts the T0 busy flag while active, and writes the updated RA0/WA0 address back to the DSP register file when the transfer completes.

## Interface
- No parameters; all widths fixed.
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- CE  in  1  clock enable; all state advances only on CLK edges with CE=1
- CMD_ST  in  1  start strobe (decoded DMA.ST qualified by the sequencer)
- CMD_DIR  in  1  0: D0->RAM, 1: RAM->D0
- CMD_RAMW  in  4  one-hot data RAM destination (DIR=0)
- CMD_PRGW  in  1  program RAM destination (DIR=0)
- CMD_RAMS  in  2  data RAM source select (DIR=1)
- CMD_ADDI  in  3  D0 address increment code
- CMD_HOLD  in  1  1: do not write back the final address
- CMD_CNT  in  8  word count, resolved by the sequencer (IMM8 or RAMx); 0 means 256
- RA0_IN / WA0_IN  in  25  current read/write D0 longword address
- RA0_WE / WA0_WE  out  1  address writeback strobes
- A0_OUT  out  25  final address for writeback
- D0_ADDR  out  25  D0 longword address
- D0_DO  out  32  D0 write data
- D0_DI  in  32  D0 read data, valid with D0_ACK
- D0_REQ  out  1  D0 cycle request
- D0_WE  out  1  D0 write (with D0_REQ)
- D0_ACK  in  1  D0 cycle complete
- RAM_RD_EN  out  1  data RAM read strobe; RAM_RDATA valid on the next CE cycle
- RAM_RD_SEL  out  2  latched CMD_RAMS
- RAM_RDATA  in  32  data RAM read data
- RAM_WE  out  4  data RAM write strobes
- PRG_WE  out  1  program RAM write strobe
- RAM_WDATA  out  32  RAM write data
- CT_INC  out  4  pulse to increment the corresponding CT0-3 after each RAM access
- BUSY  out  1  T0 flag
- DONE  out  1  one-cycle completion pulse

## Operation
- Command latched on CE cycle with CMD_ST=1 and state IDLE. CMD_ST while BUSY is ignored.
- Working address: RA0_IN when DIR=0, WA0_IN when DIR=1. Counter is 9 bits: CMD_CNT, with 0 loaded as 256.
- Increment (longwords): DIR=0 ADDI 0..7 -> 0,0,1,2,4,8,16,32. DIR=1 ADDI=1 -> 1, all other codes -> 0. The address wraps modulo 2^25.
- States: IDLE, RD_BUS, WR_RAM, RD_RAM, WR_BUS, WB.
- DIR=0: RD_BUS (D0_REQ=1, D0_WE=0, D0_ADDR=addr) holds until D0_ACK. On ACK: latch D0_DI, add increment to addr, go to WR_RAM.
- WR_RAM: RAM_WDATA=latched word. Pulse RAM_WE=CMD_RAMW or PRG_WE=CMD_PRGW. CT_INC=CMD_RAMW when writing data RAM; no CT_INC on a PRG write. Decrement the counter. If the counter becomes 0 go to WB, else RD_BUS.
- DIR=1: RD_RAM pulses RAM_RD_EN and CT_INC[RAMS], then goes to WR_BUS.
- WR_BUS: latch RAM_RDATA into D0_DO on entry. Hold D0_REQ=1 and D0_WE=1 until D0_ACK. On ACK: add increment, decrement the counter, go to WB if 0 else RD_RAM.
- WB: A0_OUT=addr. If HOLD=0, pulse RA0_WE (DIR=0) or WA0_WE (DIR=1). Pulse DONE. Go to IDLE.
- RST_N low at any time, including mid-transfer:
  - State goes to IDLE.
  - All strobes, D0_REQ, BUSY and DONE go to 0; D0_ADDR, D0_DO, RAM_WDATA and A0_OUT go to 0.
  - No writeback occurs.
- CE=0 freezes state and outputs. D0_ACK is sampled only on CE cycles.

## Timing
- CMD_ST sampled at CE edge N. From N+1: BUSY=1, plus D0_REQ=1 (DIR=0) or RAM_RD_EN=1 (DIR=1).
- Per word, with zero-wait ACK, each direction takes 2 CE cycles: DIR=0 RD_BUS + WR_RAM; DIR=1 RD_RAM + WR_BUS.
- Each D0 wait cycle (REQ=1, ACK=0) adds one cycle.
- For a count of n words, total time with zero-wait ACK is 2n+1 CE cycles from the first busy cycle. WB is the last busy cycle; BUSY=0 on the following cycle.
- RAM_WE, PRG_WE, RAM_RD_EN, CT_INC, RA0_WE, WA0_WE and DONE are single-cycle pulses.

## Test plan
- DIR=0, RAMW=0001, ADDI=2, CNT=3, RA0=0x100, zero-wait ACK:
  - D0_ADDR sequence 0x100, 0x101, 0x102.
  - Three RAM_WE[0] pulses with the D0_DI values; CT_INC[0] pulsed three times.
  - RA0_WE with A0_OUT=0x103; BUSY high 7 cycles.
- DIR=1, RAMS=2, ADDI=1, CNT=2, WA0=0x1FFFFFF, HOLD=1:
  - D0 writes at 0x1FFFFFF, then 0x0000000 (wrap).
  - D0_DO equals the RAM_RDATA values; CT_INC[2] pulsed twice.
  - No WA0_WE; DONE pulses.
- CNT=0, DIR=0, ADDI=0, PRGW=1: exactly 256 PRG_WE pulses, all at the same D0_ADDR; no CT_INC; RA0 written back unchanged.
- ACK delayed 3 cycles on every word, CNT=2: D0_REQ stays high through the waits; total busy time is 5+6=11 cycles; CMD_ST issued mid-transfer is ignored.
- RST_N asserted during WR_BUS: D0_REQ, BUSY and the strobes drop immediately with no writeback; a new CMD_ST after reset runs normally.
- CE toggling 1/0 during a CNT=1 DIR=0 transfer: the cycle count doubles; data and addresses are identical to the CE=1 run.

Source files
------------

// File: rtl/scudsp_dma_engine_if.sv
// scudsp_dma_engine_if: command, D0 bus, RAM and writeback signals
// of the SCU DSP DMA engine; master is the engine, slave its surroundings.
interface scudsp_dma_engine_if;
   logic        cmd_st;
   logic        cmd_dir;
   logic [3:0]  cmd_ramw;
   logic        cmd_prgw;
   logic [1:0]  cmd_rams;
   logic [2:0]  cmd_addi;
   logic        cmd_hold;
   logic [7:0]  cmd_cnt;
   logic [24:0] ra0_in;
   logic [24:0] wa0_in;
   logic        ra0_we;
   logic        wa0_we;
   logic [24:0] a0_out;
   logic [24:0] d0_addr;
   logic [31:0] d0_do;
   logic [31:0] d0_di;
   logic        d0_req;
   logic        d0_we;
   logic        d0_ack;
   logic        ram_rd_en;
   logic [1:0]  ram_rd_sel;
   logic [31:0] ram_rdata;
   logic [3:0]  ram_we;
   logic        prg_we;
   logic [31:0] ram_wdata;
   logic [3:0]  ct_inc;
   logic        busy;
   logic        done;

   modport master (
      input  cmd_st, cmd_dir, cmd_ramw, cmd_prgw, cmd_rams,
      input  cmd_addi, cmd_hold, cmd_cnt, ra0_in, wa0_in,
      input  d0_di, d0_ack, ram_rdata,
      output ra0_we, wa0_we, a0_out, d0_addr, d0_do, d0_req,
      output d0_we, ram_rd_en, ram_rd_sel, ram_we, prg_we,
      output ram_wdata, ct_inc, busy, done
   );

   modport slave (
      output cmd_st, cmd_dir, cmd_ramw, cmd_prgw, cmd_rams,
      output cmd_addi, cmd_hold, cmd_cnt, ra0_in, wa0_in,
      output d0_di, d0_ack, ram_rdata,
      input  ra0_we, wa0_we, a0_out, d0_addr, d0_do, d0_req,
      input  d0_we, ram_rd_en, ram_rd_sel, ram_we, prg_we,
      input  ram_wdata, ct_inc, busy, done
   );
endinterface

// File: rtl/scudsp_dma_engine.sv
// scudsp_dma_engine: executes SCU DSP DMA commands, moving 32-bit
// words between the D0 bus and DSP data/program RAM.
module scudsp_dma_engine (
   input logic                 clk,
   input logic                 rst_n,
   input logic                 ce,
   scudsp_dma_engine_if.master bus
);
   typedef enum logic [2:0] {
      IDLE, RD_BUS, WR_RAM, RD_RAM, WR_BUS, WB
   } state_t;

   state_t      state;
   logic        dir;
   logic        prgw;
   logic        hold;
   logic        first;
   logic [3:0]  ramw;
   logic [1:0]  rams;
   logic [24:0] addr;
   logic [24:0] inc;
   logic [24:0] addr_nx;
   logic [8:0]  cnt;
   logic [31:0] dreg;

   function automatic logic [24:0] inc_of(input logic d,
                                          input logic [2:0] a);
      if (d) return {24'd0, a == 3'd1};
      if (a < 3'd2) return 25'd0;
      return 25'd1 << (a - 3'd2);
   endfunction

   assign addr_nx = addr + inc;

   // First WR_BUS cycle forwards the RAM output; later cycles use the copy
   assign bus.d0_do = first ? bus.ram_rdata : dreg;

   // Transfer sequencer with registered strobes and bus outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         dir            <= 1'b0;
         prgw           <= 1'b0;
         hold           <= 1'b0;
         first          <= 1'b0;
         ramw           <= 4'd0;
         rams           <= 2'd0;
         addr           <= 25'd0;
         inc            <= 25'd0;
         cnt            <= 9'd0;
         dreg           <= 32'd0;
         bus.ra0_we     <= 1'b0;
         bus.wa0_we     <= 1'b0;
         bus.a0_out     <= 25'd0;
         bus.d0_addr    <= 25'd0;
         bus.d0_req     <= 1'b0;
         bus.d0_we      <= 1'b0;
         bus.ram_rd_en  <= 1'b0;
         bus.ram_rd_sel <= 2'd0;
         bus.ram_we     <= 4'd0;
         bus.prg_we     <= 1'b0;
         bus.ram_wdata  <= 32'd0;
         bus.ct_inc     <= 4'd0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
      end else if (ce) begin
         bus.ram_we    <= 4'd0;
         bus.prg_we    <= 1'b0;
         bus.ram_rd_en <= 1'b0;
         bus.ct_inc    <= 4'd0;
         bus.ra0_we    <= 1'b0;
         bus.wa0_we    <= 1'b0;
         bus.done      <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.cmd_st) begin
                  dir            <= bus.cmd_dir;
                  ramw           <= bus.cmd_ramw;
                  prgw           <= bus.cmd_prgw;
                  rams           <= bus.cmd_rams;
                  hold           <= bus.cmd_hold;
                  bus.ram_rd_sel <= bus.cmd_rams;
                  cnt            <= {bus.cmd_cnt == 8'd0, bus.cmd_cnt};
                  inc            <= inc_of(bus.cmd_dir, bus.cmd_addi);
                  bus.busy       <= 1'b1;
                  if (!bus.cmd_dir) begin
                     addr        <= bus.ra0_in;
                     bus.d0_addr <= bus.ra0_in;
                     bus.d0_req  <= 1'b1;
                     bus.d0_we   <= 1'b0;
                     state       <= RD_BUS;
                  end else begin
                     addr          <= bus.wa0_in;
                     bus.ram_rd_en <= 1'b1;
                     bus.ct_inc    <= 4'd1 << bus.cmd_rams;
                     state         <= RD_RAM;
                  end
               end
            end
            RD_BUS: begin
               if (bus.d0_ack) begin
                  bus.ram_wdata <= bus.d0_di;
                  addr          <= addr_nx;
                  bus.d0_req    <= 1'b0;
                  bus.ram_we    <= ramw;
                  bus.prg_we    <= prgw;
                  bus.ct_inc    <= ramw;
                  state         <= WR_RAM;
               end
            end
            WR_RAM: begin
               cnt <= cnt - 9'd1;
               if (cnt == 9'd1) begin
                  bus.a0_out <= addr;
                  bus.ra0_we <= !hold;
                  bus.done   <= 1'b1;
                  state      <= WB;
               end else begin
                  bus.d0_addr <= addr;
                  bus.d0_req  <= 1'b1;
                  state       <= RD_BUS;
               end
            end
            RD_RAM: begin
               bus.d0_addr <= addr;
               bus.d0_req  <= 1'b1;
               bus.d0_we   <= 1'b1;
               first       <= 1'b1;
               state       <= WR_BUS;
            end
            WR_BUS: begin
               if (first) begin
                  dreg  <= bus.ram_rdata;
                  first <= 1'b0;
               end
               if (bus.d0_ack) begin
                  addr       <= addr_nx;
                  cnt        <= cnt - 9'd1;
                  bus.d0_req <= 1'b0;
                  bus.d0_we  <= 1'b0;
                  if (cnt == 9'd1) begin
                     bus.a0_out <= addr_nx;
                     bus.wa0_we <= !hold;
                     bus.done   <= 1'b1;
                     state      <= WB;
                  end else begin
                     bus.ram_rd_en <= 1'b1;
                     bus.ct_inc    <= 4'd1 << rams;
                     state         <= RD_RAM;
                  end
               end
            end
            WB: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_scudsp_dma_engine.sv
// tb_scudsp_dma_engine: randomized D0/RAM responders and a queue-based
// reference of the expected transfer for each DMA command.
module tb_scudsp_dma_engine;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ce = 1'b1;

   scudsp_dma_engine_if bus();

   scudsp_dma_engine dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (ce),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   bit          ce_mode = 1'b0;
   int          waitn = 0;
   int          wcnt = 0;
   logic [24:0] ob_addr[$];
   bit          ob_we[$];
   logic [31:0] ob_dat[$];
   logic [31:0] ob_rw[$];
   logic [3:0]  ob_mask[$];
   logic [31:0] gen_di[$];
   logic [31:0] gen_rd[$];
   int          prg_cnt, busy_ce, busy_clk, done_cnt;
   int          ra0_cnt, wa0_cnt;
   int          ct_cnt[4];
   logic [24:0] wb_a0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_obs();
      ob_addr.delete(); ob_we.delete(); ob_dat.delete();
      ob_rw.delete(); ob_mask.delete();
      gen_di.delete(); gen_rd.delete();
      prg_cnt = 0; busy_ce = 0; busy_clk = 0; done_cnt = 0;
      ra0_cnt = 0; wa0_cnt = 0; wcnt = 0; wb_a0 = '0;
      for (int i = 0; i < 4; i++) ct_cnt[i] = 0;
   endtask

   // Bus/RAM responder and observer: one step per clock, at the falling edge
   always @(negedge clk) begin
      ce = ce_mode ? !ce : 1'b1;
      bus.d0_ack = 1'b0;
      if (rst_n) begin
         if (bus.busy) busy_clk++;
         if (ce) begin
            if (bus.busy) busy_ce++;
            if (bus.d0_req) begin
               if (wcnt >= waitn) begin
                  wcnt = 0;
                  bus.d0_ack = 1'b1;
                  ob_addr.push_back(bus.d0_addr);
                  ob_we.push_back(bus.d0_we);
                  if (bus.d0_we) ob_dat.push_back(bus.d0_do);
                  else begin
                     bus.d0_di = $urandom;
                     gen_di.push_back(bus.d0_di);
                  end
               end else wcnt++;
            end
            if ((|bus.ram_we) || bus.prg_we) begin
               ob_mask.push_back(bus.ram_we);
               ob_rw.push_back(bus.ram_wdata);
            end
            if (bus.prg_we) prg_cnt++;
            for (int i = 0; i < 4; i++) ct_cnt[i] += int'(bus.ct_inc[i]);
            if (bus.done) begin
               done_cnt++;
               wb_a0 = bus.a0_out;
            end
            ra0_cnt += int'(bus.ra0_we);
            wa0_cnt += int'(bus.wa0_we);
            if (bus.ram_rd_en) begin
               bus.ram_rdata = $urandom;
               gen_rd.push_back(bus.ram_rdata);
            end
         end
      end
   end

   task automatic issue(input bit dir, input logic [3:0] ramw,
                        input bit prgw, input logic [1:0] rams,
                        input logic [2:0] addi, input bit hold,
                        input logic [7:0] cnt, input logic [24:0] a0);
      bus.cmd_dir  = dir;
      bus.cmd_ramw = ramw;
      bus.cmd_prgw = prgw;
      bus.cmd_rams = rams;
      bus.cmd_addi = addi;
      bus.cmd_hold = hold;
      bus.cmd_cnt  = cnt;
      bus.ra0_in   = dir ? 25'($urandom) : a0;
      bus.wa0_in   = dir ? a0 : 25'($urandom);
      bus.cmd_st   = 1'b1;
      do @(posedge clk); while (!ce);
      #1 bus.cmd_st = 1'b0;
   endtask

   task automatic run(input string tag, input bit dir,
                      input logic [3:0] ramw, input bit prgw,
                      input logic [1:0] rams, input logic [2:0] addi,
                      input bit hold, input logic [7:0] cnt,
                      input logic [24:0] a0, input int wn,
                      input bit cem, input bit midst);
      int          n;
      int          steps[8];
      logic [24:0] inc;
      logic [24:0] ea;
      int          ebusy;
      steps = '{0, 0, 1, 2, 4, 8, 16, 32};
      n = (cnt == 8'd0) ? 256 : int'(cnt);
      if (dir) inc = (addi == 3'd1) ? 25'd1 : 25'd0;
      else inc = 25'(steps[addi]);
      ebusy = 2 * n + 1 + n * wn;
      @(posedge clk); #1;
      clear_obs();
      waitn = wn;
      ce_mode = cem;
      issue(dir, ramw, prgw, rams, addi, hold, cnt, a0);
      for (int k = 0; k < 4000 && done_cnt == 0; k++) begin
         @(posedge clk); #1;
         bus.cmd_st = midst && (k == 4);
      end
      bus.cmd_st = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      ce_mode = 1'b0;
      check({tag, "/done"}, 64'(done_cnt), 64'd1);
      check({tag, "/idle"}, 64'(bus.busy), 64'd0);
      check({tag, "/nbus"}, 64'(ob_addr.size()), 64'(n));
      for (int k = 0; k < ob_addr.size(); k++) begin
         ea = a0 + 25'(k) * inc;
         check({tag, "/addr"}, 64'(ob_addr[k]), 64'(ea));
         check({tag, "/we"}, 64'(ob_we[k]), 64'(dir));
      end
      if (!dir) begin
         check({tag, "/nram"}, 64'(ob_rw.size()), 64'(n));
         for (int k = 0; k < ob_rw.size() && k < gen_di.size(); k++) begin
            check({tag, "/wdata"}, 64'(ob_rw[k]), 64'(gen_di[k]));
            check({tag, "/mask"}, 64'(ob_mask[k]), 64'(ramw));
         end
         check({tag, "/prg"}, 64'(prg_cnt), prgw ? 64'(n) : 64'd0);
         for (int i = 0; i < 4; i++)
            check({tag, "/ct"}, 64'(ct_cnt[i]), ramw[i] ? 64'(n) : 64'd0);
      end else begin
         check({tag, "/nrd"}, 64'(ob_dat.size()), 64'(n));
         for (int k = 0; k < ob_dat.size() && k < gen_rd.size(); k++)
            check({tag, "/do"}, 64'(ob_dat[k]), 64'(gen_rd[k]));
         for (int i = 0; i < 4; i++)
            check({tag, "/ct"}, 64'(ct_cnt[i]),
                  (i == int'(rams)) ? 64'(n) : 64'd0);
         check({tag, "/rdsel"}, 64'(bus.ram_rd_sel), 64'(rams));
      end
      check({tag, "/busy"}, 64'(busy_ce), 64'(ebusy));
      if (cem) check({tag, "/busyclk"}, 64'(busy_clk), 64'(2 * ebusy));
      check({tag, "/a0"}, 64'(wb_a0), 64'(25'(a0 + 25'(n) * inc)));
      check({tag, "/ra0we"}, 64'(ra0_cnt), 64'(!dir && !hold));
      check({tag, "/wa0we"}, 64'(wa0_cnt), 64'(dir && !hold));
   endtask

   initial begin
      bus.cmd_st = 0; bus.cmd_dir = 0; bus.cmd_ramw = 0;
      bus.cmd_prgw = 0; bus.cmd_rams = 0; bus.cmd_addi = 0;
      bus.cmd_hold = 0; bus.cmd_cnt = 0; bus.ra0_in = 0;
      bus.wa0_in = 0; bus.d0_di = 0; bus.d0_ack = 0;
      bus.ram_rdata = 0;
      clear_obs();
      #12;
      check("rst/busy", 64'(bus.busy), 64'd0);
      check("rst/req", 64'(bus.d0_req), 64'd0);
      check("rst/done", 64'(bus.done), 64'd0);
      check("rst/addr", 64'(bus.d0_addr), 64'd0);
      check("rst/a0", 64'(bus.a0_out), 64'd0);
      check("rst/do", 64'(bus.d0_do), 64'd0);
      check("rst/wdata", 64'(bus.ram_wdata), 64'd0);
      rst_n = 1'b1;

      run("t1", 0, 4'b0001, 0, 2'd0, 3'd2, 0, 8'd3, 25'h100, 0, 0, 0);
      run("t2", 1, 4'b0000, 0, 2'd2, 3'd1, 1, 8'd2, 25'h1FFFFFF, 0, 0, 0);
      run("t3", 0, 4'b0000, 1, 2'd0, 3'd0, 0, 8'd0, 25'h0ABCDE, 0, 0, 0);
      run("t4", 0, 4'b0100, 0, 2'd0, 3'd3, 0, 8'd2, 25'h040, 3, 0, 1);
      run("t5", 0, 4'b0010, 0, 2'd0, 3'd4, 0, 8'd1, 25'h200, 0, 1, 0);

      @(posedge clk); #1;
      clear_obs();
      waitn = 3;
      issue(1, 4'd0, 0, 2'd1, 3'd1, 0, 8'd4, 25'h1234);
      for (int k = 0; k < 50 && !(bus.d0_req && bus.d0_we); k++) begin
         @(posedge clk); #1;
      end
      check("rst/inwrbus", 64'(bus.d0_req && bus.d0_we), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst/mid_req", 64'(bus.d0_req), 64'd0);
      check("rst/mid_busy", 64'(bus.busy), 64'd0);
      check("rst/mid_strb", 64'({bus.ram_rd_en, bus.ct_inc, bus.wa0_we,
                                  bus.done, bus.ram_we}), 64'd0);
      check("rst/mid_do", 64'(bus.d0_do), 64'd0);
      check("rst/mid_addr", 64'(bus.d0_addr), 64'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst/no_wb", 64'(wa0_cnt + done_cnt), 64'd0);
      run("t6", 1, 4'd0, 0, 2'd3, 3'd1, 0, 8'd3, 25'h777, 0, 0, 0);

      for (int r = 0; r < 15; r++) begin
         run("rnd", 1'($urandom), 4'd1 << $urandom_range(0, 3),
             1'b0, 2'($urandom), 3'($urandom), 1'($urandom),
             8'($urandom_range(1, 8)), 25'($urandom),
             int'($urandom_range(0, 2)), 1'($urandom), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
